// File: rtl/sgdmac_desc_ctrl.sv
// ============================================================================
// sgdmac_desc_ctrl
// ----------------------------------------------------------------------------
// Scatter-gather descriptor controller for the SGDMAC.  A start pulse from the
// APB configuration block launches a walk of a linked list of 16-byte
// descriptors in memory.  Each descriptor is fetched one word at a time over a
// simple request/grant/valid read port, then a single copy is launched on the
// DMA engine and the controller waits for the engine to report completion
// before following the next pointer.
//
// Descriptor layout (word aligned):
//    word0 = source address
//    word1 = destination address
//    word2 = byte length, only bits [LEN_W-1:0] are used
//    word3 = next descriptor pointer, 0 terminates the chain
//
// Ports:
//    clk              system clock, rising edge
//    rst_n            asynchronous active-low reset
//    start_i          single-cycle start pulse (only honoured while idle)
//    start_pointer_i  byte address of the first descriptor
//    done_o           high while idle, low while a chain is being walked
//    err_o            sticky misaligned-pointer flag, cleared by a new start
//    desc_cnt_o       descriptors completed since the last accepted start
//    rd_req_o         descriptor word read request
//    rd_addr_o        descriptor word read address
//    rd_gnt_i         read request accepted this cycle
//    rd_valid_i       read data valid
//    rd_data_i        read data
//    eng_start_o      one-cycle engine launch pulse
//    eng_src_o        engine source address
//    eng_dst_o        engine destination address
//    eng_len_o        engine byte count
//    eng_done_i       one-cycle engine completion pulse
// ============================================================================
module sgdmac_desc_ctrl #(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [31:0]      start_pointer_i,
   output logic             done_o,
   output logic             err_o,
   output logic [15:0]      desc_cnt_o,
   output logic             rd_req_o,
   output logic [31:0]      rd_addr_o,
   input  logic             rd_gnt_i,
   input  logic             rd_valid_i,
   input  logic [31:0]      rd_data_i,
   output logic             eng_start_o,
   output logic [31:0]      eng_src_o,
   output logic [31:0]      eng_dst_o,
   output logic [LEN_W-1:0] eng_len_o,
   input  logic             eng_done_i
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_DATA,
      ISSUE,
      WAIT_ENG
   } state_t;

   state_t           r_state;
   logic [31:0]      r_ptr;
   logic [1:0]       r_wordIdx;
   logic [31:0]      r_rdAddr;

   // Fetch-side copies of the descriptor; kept apart from the engine outputs
   // so the engine sees stable values while the next descriptor is fetched.
   logic [31:0]      r_src;
   logic [31:0]      r_dst;
   logic [LEN_W-1:0] r_len;
   logic [31:0]      r_next;

   logic [31:0]      r_engSrc;
   logic [31:0]      r_engDst;
   logic [LEN_W-1:0] r_engLen;
   logic             r_err;
   logic [15:0]      r_descCnt;

   logic             w_lastWord;
   logic             w_skipDesc;
   logic             w_advance;
   logic [31:0]      w_nextPtr;
   logic [31:0]      w_wordOffset;

   // A descriptor is finished either when the engine reports done, or right
   // after word3 arrives if its length is zero (no engine launch at all).
   // In the zero-length case the next pointer is still on the read bus, so it
   // is taken from rd_data_i rather than from the captured register.
   always_comb begin
      w_lastWord   = (r_wordIdx == 2'd3);
      w_skipDesc   = (r_state == WAIT_DATA) && rd_valid_i && w_lastWord &&
                     (r_len == '0);
      w_advance    = w_skipDesc || ((r_state == WAIT_ENG) && eng_done_i);
      w_nextPtr    = (r_state == WAIT_DATA) ? rd_data_i : r_next;
      w_wordOffset = {28'd0, r_wordIdx + 2'd1, 2'b00};
   end

   // Main controller: sequencing, descriptor capture and all registered
   // outputs.  Chain-advance is applied after the per-state logic so that it
   // overrides the state transition chosen there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_ptr     <= '0;
         r_wordIdx <= '0;
         r_rdAddr  <= '0;
         r_src     <= '0;
         r_dst     <= '0;
         r_len     <= '0;
         r_next    <= '0;
         r_engSrc  <= '0;
         r_engDst  <= '0;
         r_engLen  <= '0;
         r_err     <= 1'b0;
         r_descCnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_ptr     <= start_pointer_i;
                  r_rdAddr  <= start_pointer_i;
                  r_wordIdx <= '0;
                  r_descCnt <= '0;
                  r_err     <= (start_pointer_i[1:0] != 2'b00);
                  if (start_pointer_i[1:0] == 2'b00) begin
                     r_state <= REQ;
                  end
               end
            end

            REQ: begin
               if (rd_gnt_i) begin
                  r_state <= WAIT_DATA;
               end
            end

            WAIT_DATA: begin
               if (rd_valid_i) begin
                  case (r_wordIdx)
                     2'd0:    r_src  <= rd_data_i;
                     2'd1:    r_dst  <= rd_data_i;
                     2'd2:    r_len  <= rd_data_i[LEN_W-1:0];
                     default: r_next <= rd_data_i;
                  endcase
                  if (!w_lastWord) begin
                     r_wordIdx <= r_wordIdx + 2'd1;
                     r_rdAddr  <= r_ptr + w_wordOffset;
                     r_state   <= REQ;
                  end else if (r_len != '0) begin
                     r_engSrc <= r_src;
                     r_engDst <= r_dst;
                     r_engLen <= r_len;
                     r_state  <= ISSUE;
                  end
               end
            end

            ISSUE: begin
               r_state <= WAIT_ENG;
            end

            WAIT_ENG: begin
            end

            default: begin
               r_state <= IDLE;
            end
         endcase

         if (w_advance) begin
            r_descCnt <= r_descCnt + 16'd1;
            if (w_nextPtr == 32'd0) begin
               r_state <= IDLE;
            end else if (w_nextPtr[1:0] != 2'b00) begin
               r_err   <= 1'b1;
               r_state <= IDLE;
            end else begin
               r_ptr     <= w_nextPtr;
               r_rdAddr  <= w_nextPtr;
               r_wordIdx <= '0;
               r_state   <= REQ;
            end
         end
      end
   end

   // Status and handshake outputs are pure decodes of the registered state.
   assign done_o      = (r_state == IDLE);
   assign rd_req_o    = (r_state == REQ);
   assign eng_start_o = (r_state == ISSUE);

   assign err_o       = r_err;
   assign desc_cnt_o  = r_descCnt;
   assign rd_addr_o   = r_rdAddr;
   assign eng_src_o   = r_engSrc;
   assign eng_dst_o   = r_engDst;
   assign eng_len_o   = r_engLen;

endmodule

// File: tb/tb_sgdmac_desc_ctrl.sv
// ============================================================================
// tb_sgdmac_desc_ctrl
// ----------------------------------------------------------------------------
// Directed bench for the scatter-gather descriptor controller.  A small word
// memory answers descriptor reads with programmable grant/valid delays, and a
// simple engine model logs every launch and answers with a done pulse.
// ============================================================================
module tb_sgdmac_desc_ctrl;

   localparam int LEN_W = 16;

   logic             clk;
   logic             rst_n;
   logic             start_i;
   logic [31:0]      start_pointer_i;
   logic             done_o;
   logic             err_o;
   logic [15:0]      desc_cnt_o;
   logic             rd_req_o;
   logic [31:0]      rd_addr_o;
   logic             rd_gnt_i;
   logic             rd_valid_i;
   logic [31:0]      rd_data_i;
   logic             eng_start_o;
   logic [31:0]      eng_src_o;
   logic [31:0]      eng_dst_o;
   logic [LEN_W-1:0] eng_len_o;
   logic             eng_done_i;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] mem [0:255];
   int          gntDelay   = 0;
   int          validDelay = 0;
   int          engDelay   = 1;
   bit          engAuto    = 1'b1;
   bit          lateDone   = 1'b0;

   logic [31:0] addrLog [$];
   logic [31:0] srcLog  [$];
   logic [31:0] dstLog  [$];
   logic [31:0] lenLog  [$];

   sgdmac_desc_ctrl #(.LEN_W(LEN_W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start_i         (start_i),
      .start_pointer_i (start_pointer_i),
      .done_o          (done_o),
      .err_o           (err_o),
      .desc_cnt_o      (desc_cnt_o),
      .rd_req_o        (rd_req_o),
      .rd_addr_o       (rd_addr_o),
      .rd_gnt_i        (rd_gnt_i),
      .rd_valid_i      (rd_valid_i),
      .rd_data_i       (rd_data_i),
      .eng_start_o     (eng_start_o),
      .eng_src_o       (eng_src_o),
      .eng_dst_o       (eng_dst_o),
      .eng_len_o       (eng_len_o),
      .eng_done_i      (eng_done_i)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the run ever wedges
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Memory responder: one read at a time, grant after gntDelay stall cycles,
   // data valid validDelay cycles after the grant.  While stalled the request
   // and address must hold, and no new request may appear before data returns.
   initial begin
      logic [31:0] addr;
      rd_gnt_i   = 1'b0;
      rd_valid_i = 1'b0;
      rd_data_i  = '0;
      forever begin
         @(posedge clk); #1;
         rd_gnt_i   = 1'b0;
         rd_valid_i = 1'b0;
         if (rd_req_o && rst_n) begin
            addr = rd_addr_o;
            addrLog.push_back(addr);
            for (int i = 0; i < gntDelay; i++) begin
               @(posedge clk); #1;
               checkOutput("stallReq", {31'd0, rd_req_o}, 32'd1);
               checkOutput("stallAddr", rd_addr_o, addr);
            end
            rd_gnt_i = 1'b1;
            @(posedge clk); #1;
            rd_gnt_i = 1'b0;
            for (int i = 0; i < validDelay; i++) begin
               @(posedge clk); #1;
               checkOutput("reqWhileOutstanding", {31'd0, rd_req_o}, 32'd0);
            end
            rd_valid_i = 1'b1;
            rd_data_i  = mem[addr[9:2]];
         end
      end
   end

   // Engine model: answers each launch with a done pulse engDelay cycles
   // later; lateDone lets the stimulus inject a stray done pulse.
   initial begin
      eng_done_i = 1'b0;
      forever begin
         @(posedge clk); #1;
         eng_done_i = lateDone;
         if (eng_start_o && engAuto) begin
            for (int i = 0; i < engDelay; i++) begin
               @(posedge clk); #1;
            end
            eng_done_i = 1'b1;
         end
      end
   end

   // Launch monitor: one log entry per cycle that eng_start_o is high
   always @(negedge clk) begin
      if (eng_start_o) begin
         srcLog.push_back(eng_src_o);
         dstLog.push_back(eng_dst_o);
         lenLog.push_back({16'd0, eng_len_o});
      end
   end

   task automatic loadDesc(input logic [31:0] addr, input logic [31:0] src,
                           input logic [31:0] dst, input logic [31:0] len,
                           input logic [31:0] nxt);
      int base;
      base = int'(addr[9:2]);
      mem[base]     = src;
      mem[base + 1] = dst;
      mem[base + 2] = len;
      mem[base + 3] = nxt;
   endtask

   task automatic clearLogs();
      addrLog.delete();
      srcLog.delete();
      dstLog.delete();
      lenLog.delete();
   endtask

   // Pulses start for one cycle; returns just after the edge that samples it
   task automatic applyStimulus(input logic [31:0] ptr);
      @(posedge clk); #1;
      start_i         = 1'b1;
      start_pointer_i = ptr;
      @(posedge clk); #1;
      start_i         = 1'b0;
   endtask

   // Counts cycles until done_o is seen high; cycle 1 is the cycle right after
   // the start edge.  Optionally pulses a stray start in the middle.
   task automatic waitDone(input bit injectStart, output int cycles,
                           output logic firstDone, output logic firstReq,
                           output logic firstErr);
      cycles    = 0;
      firstDone = 1'b1;
      firstReq  = 1'b0;
      firstErr  = 1'b1;
      while (cycles < 300) begin
         @(negedge clk);
         cycles++;
         if (cycles == 1) begin
            firstDone = done_o;
            firstReq  = rd_req_o;
            firstErr  = err_o;
         end
         if (injectStart && cycles == 7) begin
            start_i         = 1'b1;
            start_pointer_i = 32'h0000_0302;
         end
         if (injectStart && cycles == 8) begin
            start_i = 1'b0;
         end
         if (done_o) break;
      end
   endtask

   task automatic checkLaunch(input int idx, input logic [31:0] src,
                              input logic [31:0] dst, input logic [31:0] len);
      if (idx < srcLog.size()) begin
         checkOutput($sformatf("engSrc%0d", idx), srcLog[idx], src);
         checkOutput($sformatf("engDst%0d", idx), dstLog[idx], dst);
         checkOutput($sformatf("engLen%0d", idx), lenLog[idx], len);
      end else begin
         checkOutput($sformatf("engLaunch%0d", idx), srcLog.size(), idx + 1);
      end
   endtask

   task automatic checkReads(input logic [31:0] base);
      checkOutput("readCount", addrLog.size(), 32'd4);
      for (int i = 0; i < 4 && i < addrLog.size(); i++) begin
         checkOutput($sformatf("readAddr%0d", i), addrLog[i], base + 32'(4 * i));
      end
   endtask

   // Directed test sequence
   initial begin
      int   cycles;
      logic fDone, fReq, fErr;

      rst_n           = 1'b0;
      start_i         = 1'b0;
      start_pointer_i = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      $display("[TB] reset state");
      @(negedge clk);
      checkOutput("rstDone", {31'd0, done_o}, 32'd1);
      checkOutput("rstErr", {31'd0, err_o}, 32'd0);
      checkOutput("rstCnt", {16'd0, desc_cnt_o}, 32'd0);
      checkOutput("rstReq", {31'd0, rd_req_o}, 32'd0);
      checkOutput("rstAddr", rd_addr_o, 32'd0);
      checkOutput("rstEngStart", {31'd0, eng_start_o}, 32'd0);
      checkOutput("rstEngSrc", eng_src_o, 32'd0);
      checkOutput("rstEngDst", eng_dst_o, 32'd0);
      checkOutput("rstEngLen", {16'd0, eng_len_o}, 32'd0);

      $display("[TB] single descriptor");
      loadDesc(32'h100, 32'h1000, 32'h2000, 32'd64, 32'h0);
      clearLogs();
      applyStimulus(32'h100);
      waitDone(1'b0, cycles, fDone, fReq, fErr);
      checkOutput("singleStartDone", {31'd0, fDone}, 32'd0);
      checkOutput("singleStartReq", {31'd0, fReq}, 32'd1);
      checkOutput("singleCycles", cycles, 32'd11);
      checkOutput("singleCnt", {16'd0, desc_cnt_o}, 32'd1);
      checkReads(32'h100);
      checkOutput("singleLaunches", srcLog.size(), 32'd1);
      checkLaunch(0, 32'h1000, 32'h2000, 32'd64);
      repeat (3) @(negedge clk);
      checkOutput("singleEngHold", eng_src_o, 32'h1000);

      $display("[TB] three descriptor chain");
      loadDesc(32'h100, 32'hA000, 32'hB000, 32'd16, 32'h200);
      loadDesc(32'h200, 32'hC000, 32'hD000, 32'd32, 32'h300);
      loadDesc(32'h300, 32'hE000, 32'hF000, 32'd48, 32'h0);
      clearLogs();
      applyStimulus(32'h100);
      waitDone(1'b0, cycles, fDone, fReq, fErr);
      checkOutput("chainCycles", cycles, 32'd31);
      checkOutput("chainCnt", {16'd0, desc_cnt_o}, 32'd3);
      checkOutput("chainReads", addrLog.size(), 32'd12);
      checkOutput("chainLaunches", srcLog.size(), 32'd3);
      checkLaunch(0, 32'hA000, 32'hB000, 32'd16);
      checkLaunch(1, 32'hC000, 32'hD000, 32'd32);
      checkLaunch(2, 32'hE000, 32'hF000, 32'd48);

      $display("[TB] zero-length middle descriptor");
      loadDesc(32'h200, 32'hC000, 32'hD000, 32'hFFFF_0000, 32'h300);
      clearLogs();
      applyStimulus(32'h100);
      waitDone(1'b0, cycles, fDone, fReq, fErr);
      checkOutput("zeroCycles", cycles, 32'd29);
      checkOutput("zeroCnt", {16'd0, desc_cnt_o}, 32'd3);
      checkOutput("zeroLaunches", srcLog.size(), 32'd2);
      checkLaunch(0, 32'hA000, 32'hB000, 32'd16);
      checkLaunch(1, 32'hE000, 32'hF000, 32'd48);

      $display("[TB] misaligned start pointer");
      clearLogs();
      applyStimulus(32'h102);
      @(negedge clk);
      checkOutput("badStartErr", {31'd0, err_o}, 32'd1);
      checkOutput("badStartDone", {31'd0, done_o}, 32'd1);
      checkOutput("badStartReq", {31'd0, rd_req_o}, 32'd0);
      checkOutput("badStartCnt", {16'd0, desc_cnt_o}, 32'd0);
      repeat (5) @(negedge clk);
      checkOutput("badStartNoReads", addrLog.size(), 32'd0);
      checkOutput("badStartStillDone", {31'd0, done_o}, 32'd1);

      $display("[TB] misaligned next pointer");
      loadDesc(32'h100, 32'h1000, 32'h2000, 32'd64, 32'h206);
      clearLogs();
      applyStimulus(32'h100);
      waitDone(1'b0, cycles, fDone, fReq, fErr);
      checkOutput("badNextStartErr", {31'd0, fErr}, 32'd0);
      checkOutput("badNextCycles", cycles, 32'd11);
      checkOutput("badNextErr", {31'd0, err_o}, 32'd1);
      checkOutput("badNextCnt", {16'd0, desc_cnt_o}, 32'd1);
      checkOutput("badNextLaunches", srcLog.size(), 32'd1);

      $display("[TB] valid start clears error");
      loadDesc(32'h100, 32'h1000, 32'h2000, 32'd64, 32'h0);
      clearLogs();
      applyStimulus(32'h100);
      waitDone(1'b0, cycles, fDone, fReq, fErr);
      checkOutput("clearErrFirst", {31'd0, fErr}, 32'd0);
      checkOutput("clearErrEnd", {31'd0, err_o}, 32'd0);
      checkOutput("clearErrCnt", {16'd0, desc_cnt_o}, 32'd1);

      $display("[TB] read back-pressure with stray start");
      gntDelay   = 5;
      validDelay = 3;
      loadDesc(32'h100, 32'h1234, 32'h5678, 32'd200, 32'h0);
      clearLogs();
      applyStimulus(32'h100);
      waitDone(1'b1, cycles, fDone, fReq, fErr);
      checkOutput("bpCycles", cycles, 32'd43);
      checkOutput("bpErr", {31'd0, err_o}, 32'd0);
      checkOutput("bpCnt", {16'd0, desc_cnt_o}, 32'd1);
      checkReads(32'h100);
      checkLaunch(0, 32'h1234, 32'h5678, 32'd200);
      gntDelay   = 0;
      validDelay = 0;

      $display("[TB] reset during engine wait");
      engAuto = 1'b0;
      clearLogs();
      applyStimulus(32'h100);
      for (int i = 0; i < 100 && srcLog.size() == 0; i++) @(negedge clk);
      checkOutput("rstMidLaunch", srcLog.size(), 32'd1);
      repeat (2) @(negedge clk);
      checkOutput("rstMidBusy", {31'd0, done_o}, 32'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("rstMidDone", {31'd0, done_o}, 32'd1);
      checkOutput("rstMidAddr", rd_addr_o, 32'd0);
      checkOutput("rstMidEngSrc", eng_src_o, 32'd0);
      checkOutput("rstMidEngLen", {16'd0, eng_len_o}, 32'd0);
      checkOutput("rstMidCnt", {16'd0, desc_cnt_o}, 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      lateDone = 1'b1;
      @(negedge clk);
      lateDone = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("lateDoneDone", {31'd0, done_o}, 32'd1);
      checkOutput("lateDoneCnt", {16'd0, desc_cnt_o}, 32'd0);
      checkOutput("lateDoneReq", {31'd0, rd_req_o}, 32'd0);
      checkOutput("lateDoneLaunches", srcLog.size(), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
